ram_write_port: RTL and testbench

- Downstream of the flash boot loader: takes its one-cycle RAM write requests (address, data, strobe) and turns them into correctly timed external SRAM write cycles (CE#/WE#/data-enable with setup, pulse and hold).
- One-entry pending buffer absorbs a request that arrives while a write cycle is in progress. A sticky overrun flag reports dropped requests.
- Keeps a running byte checksum and write count, so the boot image can be checked after load.

---
 rtl/ram_write_port_pkg.sv | 24 ++
 rtl/ram_write_port_slot.sv | 48 ++++
 rtl/ram_write_port.sv | 183 ++++++++++++++++++
 tb/tb_ram_write_port.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_write_port_pkg.sv
// ram_write_port_pkg
//   Shared definitions for the SRAM write port: FSM state encoding,
//   default write-cycle timing, SRAM address width and counter widths.
package ram_write_port_pkg;

  localparam int ADDR_BITS_DEF    = 19;
  localparam int SETUP_CYCLES_DEF = 1;
  localparam int PULSE_CYCLES_DEF = 2;
  localparam int HOLD_CYCLES_DEF  = 1;

  // Phase timer width; covers phase lengths up to 256 cycles.
  localparam int CNT_BITS = 8;

  localparam int COUNT_BITS = 20;
  localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_write_port_slot.sv
// ram_write_port_slot
//   One-entry pending buffer for write requests that arrive while an SRAM
//   write cycle is in progress.
// Ports:
//   clock, reset_n          clock, async active-low reset
//   req                     request routed to the slot this cycle
//   req_address, req_data   request contents
//   drain                   slot contents are taken by the FSM this cycle
//   valid, address, data    slot contents
//   dropped                 pulse: request lost because the slot was full
module ram_write_port_slot
  import ram_write_port_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req,
  input  logic [ADDR_BITS-1:0] req_address,
  input  logic [7:0]           req_data,
  input  logic                 drain,
  output logic                 valid,
  output logic [ADDR_BITS-1:0] address,
  output logic [7:0]           data,
  output logic                 dropped
);

  logic load;

  // A drain in the same cycle frees the slot for the incoming request.
  assign load    = req && (!valid || drain);
  assign dropped = req && valid && !drain;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid   <= 1'b0;
      address <= '0;
      data    <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      address <= req_address;
      data    <= req_data;
    end else if (drain) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_write_port.sv
// ram_write_port
//   Turns one-cycle RAM write requests into timed external SRAM write cycles
//   (setup / WE# pulse / hold), with a one-entry pending buffer, a sticky
//   overrun flag, and a running byte checksum and write count.
// Ports:
//   clock, reset_n                       clock, async active-low reset
//   req_valid, req_address, req_data     write request strobe and contents
//   clear                                sync clear of checksum/count/overrun
//   idle                                 FSM idle and pending slot empty
//   sram_address, sram_data, sram_data_oe, sram_ce_n, sram_we_n, sram_oe_n
//                                        SRAM pins
//   checksum, write_count, overrun       load status
//
// state   | meaning
// S_IDLE  | no write in progress, SRAM pins inactive
// S_SETUP | CE# low, address/data driven, WE# high
// S_PULSE | WE# low
// S_HOLD  | WE# high, CE# low, address/data held
module ram_write_port
  import ram_write_port_pkg::*;
#(
  parameter int ADDR_BITS    = ADDR_BITS_DEF,
  parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic [ADDR_BITS-1:0]  req_address,
  input  logic [7:0]            req_data,
  input  logic                  clear,
  output logic                  idle,
  output logic [ADDR_BITS-1:0]  sram_address,
  output logic [7:0]            sram_data,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_we_n,
  output logic                  sram_oe_n,
  output logic [15:0]           checksum,
  output logic [COUNT_BITS-1:0] write_count,
  output logic                  overrun
);

  localparam logic [CNT_BITS-1:0] SETUP_LOAD = CNT_BITS'(SETUP_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] PULSE_LOAD = CNT_BITS'(PULSE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] HOLD_LOAD  = CNT_BITS'(HOLD_CYCLES - 1);

  state_t              state, state_nx;
  logic [CNT_BITS-1:0] cnt, cnt_nx;

  logic                 phase_done;
  logic                 hold_done;
  logic                 fsm_free;
  logic                 start_direct;
  logic                 start_pend;
  logic                 slot_req;
  logic                 slot_valid;
  logic [ADDR_BITS-1:0] slot_address;
  logic [7:0]           slot_data;
  logic                 slot_dropped;

  assign phase_done = (cnt == '0);
  assign hold_done  = (state == S_HOLD) && phase_done;

  // The active registers can take a new request either when idle or when
  // the current write ends with nothing pending; in the latter case the
  // next write starts without an idle gap.
  assign fsm_free     = (state == S_IDLE) || (hold_done && !slot_valid);
  assign start_direct = req_valid && fsm_free;
  assign start_pend   = hold_done && slot_valid;
  assign slot_req     = req_valid && !fsm_free;

  ram_write_port_slot #(
    .ADDR_BITS (ADDR_BITS)
  ) u_slot (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (slot_req),
    .req_address (req_address),
    .req_data    (req_data),
    .drain       (start_pend),
    .valid       (slot_valid),
    .address     (slot_address),
    .data        (slot_data),
    .dropped     (slot_dropped)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = phase_done ? cnt : cnt - CNT_BITS'(1);
    sram_ce_n    = 1'b0;
    sram_we_n    = 1'b1;
    sram_data_oe = 1'b1;
    sram_oe_n    = 1'b1;
    case (state)
      S_IDLE: begin
        sram_ce_n    = 1'b1;
        sram_data_oe = 1'b0;
        if (start_direct) begin
          state_nx = S_SETUP;
          cnt_nx   = SETUP_LOAD;
        end
      end
      S_SETUP: begin
        if (phase_done) begin
          state_nx = S_PULSE;
          cnt_nx   = PULSE_LOAD;
        end
      end
      S_PULSE: begin
        sram_we_n = 1'b0;
        if (phase_done) begin
          state_nx = S_HOLD;
          cnt_nx   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (phase_done) begin
          if (start_pend || start_direct) begin
            state_nx = S_SETUP;
            cnt_nx   = SETUP_LOAD;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sram_address <= '0;
      sram_data    <= '0;
    end else if (start_pend) begin
      sram_address <= slot_address;
      sram_data    <= slot_data;
    end else if (start_direct) begin
      sram_address <= req_address;
      sram_data    <= req_data;
    end
  end

  // A clear in the same cycle as a completion discards that completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      checksum    <= '0;
      write_count <= '0;
      overrun     <= 1'b0;
    end else if (clear) begin
      checksum    <= '0;
      write_count <= '0;
      overrun     <= 1'b0;
    end else begin
      if (hold_done) begin
        checksum <= checksum + {8'h00, sram_data};
        if (write_count != COUNT_MAX) begin
          write_count <= write_count + COUNT_BITS'(1);
        end
      end
      if (slot_dropped) begin
        overrun <= 1'b1;
      end
    end
  end

  assign idle = (state == S_IDLE) && !slot_valid;

endmodule

// File: tb/tb_ram_write_port.sv
module tb_ram_write_port;

  localparam int SETUP = 1;
  localparam int PULSE = 2;
  localparam int HOLD  = 1;
  localparam int TOTAL = SETUP + PULSE + HOLD;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [18:0] req_address = '0;
  logic [7:0]  req_data = '0;
  logic        clear = 1'b0;
  logic        idle;
  logic [18:0] sram_address;
  logic [7:0]  sram_data;
  logic        sram_data_oe, sram_ce_n, sram_we_n, sram_oe_n;
  logic [15:0] checksum;
  logic [19:0] write_count;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  ram_write_port dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_address  (req_address),
    .req_data     (req_data),
    .clear        (clear),
    .idle         (idle),
    .sram_address (sram_address),
    .sram_data    (sram_data),
    .sram_data_oe (sram_data_oe),
    .sram_ce_n    (sram_ce_n),
    .sram_we_n    (sram_we_n),
    .sram_oe_n    (sram_oe_n),
    .checksum     (checksum),
    .write_count  (write_count),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  // Reference model: each accepted write occupies the port for TOTAL cycles.
  int          m_rem;
  bit          m_pend_v;
  logic [26:0] m_pend;
  logic [7:0]  m_act_d;
  logic [15:0] m_sum;
  int          m_cnt;
  bit          m_ovr;
  logic [26:0] exp_q[$];
  logic [26:0] act_q[$];

  function automatic void model_reset();
    m_rem = 0; m_pend_v = 0; m_pend = '0; m_act_d = '0;
    m_sum = '0; m_cnt = 0; m_ovr = 0;
    exp_q.delete();
  endfunction

  function automatic void model_step(bit v, logic [18:0] a, logic [7:0] d, bit c);
    bit done;
    done = (m_rem == 1);
    if (m_rem > 0) m_rem--;
    if (done) begin
      m_sum += {8'h00, m_act_d};
      if (m_cnt < (1 << 20) - 1) m_cnt++;
    end
    if (m_rem == 0 && m_pend_v) begin
      m_act_d = m_pend[7:0];
      exp_q.push_back(m_pend);
      m_rem = TOTAL;
      m_pend_v = 0;
    end
    if (v) begin
      if (m_rem == 0) begin
        m_act_d = d;
        exp_q.push_back({a, d});
        m_rem = TOTAL;
      end else if (!m_pend_v) begin
        m_pend = {a, d};
        m_pend_v = 1;
      end else begin
        m_ovr = 1;
      end
    end
    if (c) begin
      m_sum = '0; m_cnt = 0; m_ovr = 0;
    end
  endfunction

  // SRAM-side monitor: records each completed WE# pulse.
  bit          mon_in_pulse = 0;
  int          mon_len;
  logic [18:0] mon_a;
  logic [7:0]  mon_d;

  always @(negedge clock) begin
    if (!reset_n) begin
      mon_in_pulse = 0;
    end else if (!sram_we_n) begin
      checks++;
      if (sram_ce_n !== 1'b0 || sram_data_oe !== 1'b1) begin
        failures++;
        $display("FAIL we_pulse_ctrl ce_n=%b data_oe=%b required ce_n=0 data_oe=1", sram_ce_n, sram_data_oe);
      end
      if (!mon_in_pulse) begin
        mon_in_pulse = 1; mon_len = 1; mon_a = sram_address; mon_d = sram_data;
      end else begin
        mon_len++;
        checks++;
        if (sram_address !== mon_a || sram_data !== mon_d) begin
          failures++;
          $display("FAIL pulse_stable addr=%h data=%h required addr=%h data=%h", sram_address, sram_data, mon_a, mon_d);
        end
      end
    end else if (mon_in_pulse) begin
      mon_in_pulse = 0;
      checks++;
      if (mon_len != PULSE) begin
        failures++;
        $display("FAIL pulse_len got=%0d required=%0d", mon_len, PULSE);
      end
      act_q.push_back({mon_a, mon_d});
    end
  end

  task automatic drive(input bit v, input logic [18:0] a, input logic [7:0] d, input bit c);
    req_valid = v; req_address = a; req_data = d; clear = c;
    model_step(v, a, d, c);
    @(posedge clock); #1;
    req_valid = 0; clear = 0;
  endtask

  task automatic do_reset();
    reset_n = 0; req_valid = 0; clear = 0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1;
    model_reset();
    act_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 0;
    #1;
    checks++;
    if ({sram_ce_n, sram_we_n, sram_oe_n, sram_data_oe, idle, overrun} !== 6'b111010) begin
      failures++;
      $display("FAIL reset_ctrl ce/we/oe/doe/idle/ovr=%b required=111010",
               {sram_ce_n, sram_we_n, sram_oe_n, sram_data_oe, idle, overrun});
    end
    checks++;
    if (sram_address !== 19'h0 || sram_data !== 8'h0) begin
      failures++;
      $display("FAIL reset_bus addr=%h data=%h required 0/0", sram_address, sram_data);
    end
    checks++;
    if (checksum !== 16'h0 || write_count !== 20'h0) begin
      failures++;
      $display("FAIL reset_stats checksum=%h count=%0d required 0/0", checksum, write_count);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    drive(1, 19'h0E000, 8'hA5, 0);
    for (int k = 1; k <= TOTAL + 2; k++) begin
      bit exp_ce_n, exp_we_n;
      exp_ce_n = !(k >= 1 && k <= TOTAL);
      exp_we_n = !(k >= 1 + SETUP && k <= SETUP + PULSE);
      checks++;
      if (sram_ce_n !== exp_ce_n || sram_we_n !== exp_we_n || sram_data_oe !== !exp_ce_n) begin
        failures++;
        $display("FAIL single_timing cycle=N+%0d ce_n=%b we_n=%b oe=%b required ce_n=%b we_n=%b oe=%b",
                 k, sram_ce_n, sram_we_n, sram_data_oe, exp_ce_n, exp_we_n, !exp_ce_n);
      end
      if (!exp_ce_n) begin
        checks++;
        if (sram_address !== 19'h0E000 || sram_data !== 8'hA5) begin
          failures++;
          $display("FAIL single_bus cycle=N+%0d addr=%h data=%h required 0e000/a5", k, sram_address, sram_data);
        end
      end
      drive(0, '0, '0, 0);
    end
    checks++;
    if (checksum !== 16'h00A5 || write_count !== 20'd1 || idle !== 1'b1) begin
      failures++;
      $display("FAIL single_stats checksum=%h count=%0d idle=%b required 00a5/1/1", checksum, write_count, idle);
    end
    checks++;
    if (act_q.size() != 1 || act_q[0] !== {19'h0E000, 8'hA5}) begin
      failures++;
      $display("FAIL single_sram writes=%0d required one write of 0e000/a5", act_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int low_cycles = 0;
    bit seen_low = 0, ended = 0, gap = 0;
    do_reset();
    drive(1, 19'h00010, 8'h01, 0);
    for (int i = 0; i < 14; i++) begin
      if (!sram_ce_n) begin
        low_cycles++;
        if (ended) gap = 1;
        seen_low = 1;
      end else if (seen_low) begin
        ended = 1;
      end
      drive(i == 0, 19'h00011, 8'h02, 0);
    end
    checks++;
    if (low_cycles != 2 * TOTAL || gap) begin
      failures++;
      $display("FAIL b2b_ce_low cycles=%0d gap=%0d required %0d/0", low_cycles, gap, 2 * TOTAL);
    end
    checks++;
    if (checksum !== 16'h0003 || write_count !== 20'd2 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stats checksum=%h count=%0d ovr=%b required 0003/2/0", checksum, write_count, overrun);
    end
    checks++;
    if (act_q.size() != 2 || act_q[1] !== {19'h00011, 8'h02}) begin
      failures++;
      $display("FAIL b2b_sram writes=%0d required 2 with second 00011/02", act_q.size());
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 19'(i), 8'(8'h10 + i), 0);
    for (int i = 0; i < 12; i++) drive(0, '0, '0, 0);
    checks++;
    if (overrun !== 1'b1 || write_count !== 20'd2 || checksum !== 16'h0021) begin
      failures++;
      $display("FAIL overrun_stats ovr=%b count=%0d checksum=%h required 1/2/0021", overrun, write_count, checksum);
    end
    checks++;
    if (act_q.size() != 2) begin
      failures++;
      $display("FAIL overrun_sram writes=%0d required 2", act_q.size());
    end
  endtask

  task automatic test_reset_in_pulse();
    bit found = 0;
    do_reset();
    drive(1, 19'h12345, 8'h3C, 0);
    for (int i = 0; i < 10 && !found; i++) begin
      if (!sram_we_n) found = 1;
      else drive(0, '0, '0, 0);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_pulse_wait we_n never low within 10 cycles");
    end
    drive(1, 19'h00001, 8'h77, 0);
    reset_n = 0;
    #1;
    checks++;
    if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b1 || sram_data_oe !== 1'b0) begin
      failures++;
      $display("FAIL rst_pulse_pins we_n=%b ce_n=%b oe=%b required 1/1/0", sram_we_n, sram_ce_n, sram_data_oe);
    end
    @(posedge clock); #1;
    reset_n = 1;
    model_reset();
    act_q.delete();
    for (int i = 0; i < 8; i++) drive(0, '0, '0, 0);
    checks++;
    if (idle !== 1'b1 || write_count !== 20'd0 || checksum !== 16'h0 || act_q.size() != 0) begin
      failures++;
      $display("FAIL rst_pulse_after idle=%b count=%0d checksum=%h writes=%0d required 1/0/0000/0",
               idle, write_count, checksum, act_q.size());
    end
  endtask

  task automatic test_clear_completion();
    do_reset();
    drive(1, 19'h00100, 8'h55, 0);
    for (int i = 1; i < TOTAL; i++) drive(0, '0, '0, 0);
    drive(0, '0, '0, 1);
    checks++;
    if (checksum !== 16'h0 || write_count !== 20'd0) begin
      failures++;
      $display("FAIL clear_collide checksum=%h count=%0d required 0000/0", checksum, write_count);
    end
    drive(1, 19'h00101, 8'h10, 0);
    for (int i = 0; i < TOTAL + 2; i++) drive(0, '0, '0, 0);
    checks++;
    if (checksum !== 16'h0010 || write_count !== 20'd1) begin
      failures++;
      $display("FAIL clear_next checksum=%h count=%0d required 0010/1", checksum, write_count);
    end
  endtask

  task automatic test_boot_rate();
    logic [15:0] es = '0;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 2048; i++) begin
      logic [18:0] a;
      a = 19'h0E000 + 19'(i);
      es += {8'h00, a[7:0]};
      drive(1, a, a[7:0], 0);
      for (int j = 0; j < 16; j++) drive(0, '0, '0, 0);
    end
    checks++;
    if (write_count !== 20'd2048 || checksum !== es || overrun !== 1'b0) begin
      failures++;
      $display("FAIL boot_stats count=%0d checksum=%h ovr=%b required 2048/%h/0", write_count, checksum, overrun, es);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (act_q[i] !== exp_q[i]) bad++;
    checks++;
    if (act_q.size() != 2048 || exp_q.size() != 2048 || bad != 0) begin
      failures++;
      $display("FAIL boot_sram writes=%0d model=%0d bad=%0d required 2048/2048/0", act_q.size(), exp_q.size(), bad);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int bad_stats = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 2) == 0, 19'($urandom), 8'($urandom), $urandom_range(0, 39) == 0);
      if (checksum !== m_sum || write_count !== 20'(m_cnt) || overrun !== m_ovr ||
          idle !== (m_rem == 0 && !m_pend_v)) begin
        bad_stats++;
        if (bad_stats < 4)
          $display("FAIL random_stats cycle=%0d checksum=%h count=%0d ovr=%b idle=%b required %h/%0d/%b/%b",
                   i, checksum, write_count, overrun, idle, m_sum, m_cnt, m_ovr, (m_rem == 0 && !m_pend_v));
      end
    end
    checks++;
    if (bad_stats != 0) failures++;
    for (int i = 0; i < 10; i++) drive(0, '0, '0, 0);
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (act_q[i] !== exp_q[i]) bad++;
    checks++;
    if (act_q.size() != exp_q.size() || bad != 0) begin
      failures++;
      $display("FAIL random_sram writes=%0d model=%0d bad=%0d", act_q.size(), exp_q.size(), bad);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_overrun();
    test_reset_in_pulse();
    test_clear_completion();
    test_boot_rate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
